// File: rtl/bound_setter_pkg.sv
// -----------------------------------------------------------------------------
// bound_setter_pkg
// Shared types, widths and helpers for the bound setter: FSM state encoding
// (codes double as the mode output), BCD digit pair type, repeat timing
// multipliers, and the BCD <-> binary helpers used on the edit path.
// Optional feature macro used elsewhere: BOUND_SETTER_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
package bound_setter_pkg;

   localparam int BOUND_W        = 6;
   localparam int BCD_W          = 4;
   localparam int RPT_START_MULT = 50;  // hold time before repeat, in debounce periods
   localparam int RPT_STEP_MULT  = 20;  // repeat period, in debounce periods

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_EDIT_MAX = 2'b01,
      ST_EDIT_MIN = 2'b10
   } state_e;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } bcd_t;

   // tens*10 + ones without a multiplier.
   function automatic logic [BOUND_W-1:0] bcd_to_bin(input bcd_t v);
      logic [BOUND_W-1:0] t;
      t = {2'b00, v.tens};
      return (t << 3) + (t << 1) + {2'b00, v.ones};
   endfunction

   // Repeated subtraction; six steps cover every 6-bit value.
   function automatic bcd_t bin_to_bcd(input logic [BOUND_W-1:0] v);
      logic [BOUND_W-1:0] r;
      logic [BCD_W-1:0]   t;
      r = v;
      t = '0;
      for (int i = 0; i < 6; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return '{tens: t, ones: r[BCD_W-1:0]};
   endfunction

   // Increment a BCD pair, wrapping to 00 once the value reaches limit.
   function automatic bcd_t bcd_inc(input bcd_t v, input logic [BOUND_W-1:0] limit);
      bcd_t r;
      if (bcd_to_bin(v) == limit) begin
         r = '0;
      end else if (v.ones == 4'd9) begin
         r.tens = v.tens + 4'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = v.tens;
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bound_setter_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One raw active-low push-button: 2-FF synchronizer, stability counter and
// press-pulse edge detector.
//   clk, rst  : clock, asynchronous active-high reset (debounced = released)
//   key_n     : raw active-low button
//   level_o   : debounced pressed level (only with BOUND_SETTER_AUTOREPEAT_EN)
//   press_o   : one-cycle pulse on the debounced released->pressed transition
// Event semantics: press_o is a single-cycle strobe with no ready/ack; the
// consumer must act on the clock edge that follows it or the event is lost.
// The pulse appears 2 + DEBOUNCE_CYCLES cycles after the raw edge.
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
`ifdef BOUND_SETTER_AUTOREPEAT_EN
   output logic level_o,
`endif
   output logic press_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = ~key_n;  // internally 1 = pressed
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // Count only while the synchronized sample disagrees with the accepted
      // level; a single agreeing sample restarts the count from zero.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;
`ifdef BOUND_SETTER_AUTOREPEAT_EN
   assign level_o = level_q;
`endif

endmodule

// File: rtl/bound_setter.sv
// -----------------------------------------------------------------------------
// bound_setter
// Push-button editor for the LED bound flasher's max/min bounds. The user
// steps two-digit BCD values with the increment key and walks
// IDLE -> EDIT_MAX -> EDIT_MIN -> IDLE with the select key; the final select
// commits both bounds at once.
//   clk, rst   : clock, asynchronous active-high reset
//   key_n[1:0] : raw active-low buttons, [0]=increment, [1]=select/confirm
//   max_o/min_o: committed 6-bit binary bounds (change only on commit)
//   edit_tens/edit_ones : BCD digits shown (committed max in IDLE, working
//                         value while editing)
//   mode       : registered FSM state, 00 IDLE / 01 EDIT_MAX / 10 EDIT_MIN
//   upd        : one-cycle pulse on the cycle new bounds become visible
// Optional feature: define BOUND_SETTER_AUTOREPEAT_EN for increment auto-repeat.
// -----------------------------------------------------------------------------
module bound_setter
   import bound_setter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_VAL         = 31,
   parameter int DEF_MAX         = 15,
   parameter int DEF_MIN         = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         key_n,
   output logic [BOUND_W-1:0] max_o,
   output logic [BOUND_W-1:0] min_o,
   output logic [BCD_W-1:0]   edit_tens,
   output logic [BCD_W-1:0]   edit_ones,
   output logic [1:0]         mode,
   output logic               upd
);

   localparam logic [BOUND_W-1:0] MAX_VAL_B = BOUND_W'(MAX_VAL);
   localparam logic [BOUND_W-1:0] DEF_MAX_B = BOUND_W'(DEF_MAX);
   localparam logic [BOUND_W-1:0] DEF_MIN_B = BOUND_W'(DEF_MIN);

   logic inc_press, sel_press, inc_evt;

   state_e             state_q, state_d;
   bcd_t               work_q,  work_d;
   logic [BOUND_W-1:0] pend_q,  pend_d;
   logic [BOUND_W-1:0] max_q,   max_d;
   logic [BOUND_W-1:0] min_q,   min_d;
   logic               upd_q,   upd_d;

   logic [BOUND_W-1:0] work_bin;
   bcd_t               disp;

`ifdef BOUND_SETTER_AUTOREPEAT_EN
   logic inc_level, sel_level;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk(clk), .rst(rst), .key_n(key_n[0]), .level_o(inc_level), .press_o(inc_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
      .clk(clk), .rst(rst), .key_n(key_n[1]), .level_o(sel_level), .press_o(sel_press)
   );

   localparam int RPT_START = RPT_START_MULT * DEBOUNCE_CYCLES;
   localparam int RPT_STEP  = RPT_STEP_MULT * DEBOUNCE_CYCLES;
   localparam int RPT_W     = $clog2(RPT_START + 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_act_q, rpt_act_d;
   logic             rpt_fire;

   // Phase 0 (rpt_act_q=0) waits out the initial hold; phase 1 fires one
   // extra increment per step period. Anything that ends the hold or
   // touches select returns to phase 0.
   always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_act_d = rpt_act_q;
      rpt_fire  = 1'b0;
      if (!inc_level || inc_press || sel_level || sel_press || state_q == ST_IDLE) begin
         rpt_cnt_d = '0;
         rpt_act_d = 1'b0;
      end else if (!rpt_act_q) begin
         if (rpt_cnt_q == RPT_W'(RPT_START - 1)) begin
            rpt_cnt_d = '0;
            rpt_act_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end else begin
         if (rpt_cnt_q == RPT_W'(RPT_STEP - 1)) begin
            rpt_cnt_d = '0;
            rpt_fire  = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt_q <= '0;
         rpt_act_q <= 1'b0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_act_q <= rpt_act_d;
      end
   end

   assign inc_evt = inc_press | rpt_fire;
`else
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk(clk), .rst(rst), .key_n(key_n[0]), .press_o(inc_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
      .clk(clk), .rst(rst), .key_n(key_n[1]), .press_o(sel_press)
   );

   assign inc_evt = inc_press;
`endif

   assign work_bin = bcd_to_bin(work_q);

   // Select is tested first in every state so a coincident increment is
   // dropped rather than folded into the value being latched.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      pend_d  = pend_q;
      max_d   = max_q;
      min_d   = min_q;
      upd_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_press) begin
               state_d = ST_EDIT_MAX;
               work_d  = bin_to_bcd(max_q);
            end
         end
         ST_EDIT_MAX: begin
            if (sel_press) begin
               state_d = ST_EDIT_MIN;
               pend_d  = work_bin;
               // Start min editing at a legal value for the new max.
               work_d  = bin_to_bcd((min_q > work_bin) ? work_bin : min_q);
            end else if (inc_evt) begin
               work_d = bcd_inc(work_q, MAX_VAL_B);
            end
         end
         ST_EDIT_MIN: begin
            if (sel_press) begin
               state_d = ST_IDLE;
               max_d   = pend_q;
               min_d   = work_bin;
               upd_d   = 1'b1;
            end else if (inc_evt) begin
               work_d = bcd_inc(work_q, pend_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         work_q  <= bin_to_bcd(DEF_MAX_B);
         pend_q  <= DEF_MAX_B;
         max_q   <= DEF_MAX_B;
         min_q   <= DEF_MIN_B;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         pend_q  <= pend_d;
         max_q   <= max_d;
         min_q   <= min_d;
         upd_q   <= upd_d;
      end
   end

   assign disp      = (state_q == ST_IDLE) ? bin_to_bcd(max_q) : work_q;
   assign edit_tens = disp.tens;
   assign edit_ones = disp.ones;
   assign max_o     = max_q;
   assign min_o     = min_q;
   assign mode      = state_q;
   assign upd       = upd_q;

endmodule

// File: tb/tb_bound_setter.sv
// -----------------------------------------------------------------------------
// tb_bound_setter
// Directed bench for bound_setter with DEBOUNCE_CYCLES=4, MAX_VAL=31.
// Expected commits are queued when the confirming select is driven and are
// popped when upd pulses. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bound_setter;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key_n;
   logic [5:0] max_o, min_o;
   logic [3:0] edit_tens, edit_ones;
   logic [1:0] mode;
   logic       upd;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];  // {max, min} per expected commit

   bound_setter #(
      .DEBOUNCE_CYCLES(DB), .MAX_VAL(31), .DEF_MAX(15), .DEF_MIN(0)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .max_o(max_o), .min_o(min_o),
      .edit_tens(edit_tens), .edit_ones(edit_ones), .mode(mode), .upd(upd)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_digits(input string tag, input int t, input int o);
      chk({tag, "_tens"}, 32'(edit_tens), 32'(t));
      chk({tag, "_ones"}, 32'(edit_ones), 32'(o));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k);
      key_n[k] = 1'b0;
      cyc(8);
      key_n[k] = 1'b1;
      cyc(10);
   endtask

   // Confirming select: queue the expected bounds, then wait for upd.
   task automatic commit(input string tag, input logic [5:0] mx, input logic [5:0] mn);
      logic        found;
      logic [11:0] e;
      exp_q.push_back({mx, mn});
      key_n[1] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1);
         if (upd === 1'b1) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $error("FAIL %s_upd: observed no upd pulse expected one within 40 cycles", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_max"}, 32'(max_o), 32'(e[11:6]));
         chk({tag, "_min"}, 32'(min_o), 32'(e[5:0]));
         chk({tag, "_mode"}, 32'(mode), 32'd0);
         cyc(1);
         chk({tag, "_upd_one_cycle"}, 32'(upd), 32'd0);
      end
      key_n[1] = 1'b1;
      cyc(10);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic seen_upd;
      rst   = 1'b1;
      key_n = 2'b11;
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // Reset state
      chk("rst_max", 32'(max_o), 32'd15);
      chk("rst_min", 32'(min_o), 32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_upd", 32'(upd), 32'd0);
      chk_digits("rst_digits", 1, 5);

      // Basic edit: max 15 -> 19, min 0 -> 2
      press(1);
      chk("edit_max_mode", 32'(mode), 32'd1);
      chk_digits("edit_max_load", 1, 5);
      repeat (4) press(0);
      chk_digits("max_plus4", 1, 9);
      press(1);
      chk("edit_min_mode", 32'(mode), 32'd2);
      chk_digits("min_load", 0, 0);
      repeat (2) press(0);
      chk_digits("min_plus2", 0, 2);
      commit("commit_19_2", 6'd19, 6'd2);
      chk_digits("idle_shows_max", 1, 9);

      // Increment ignored in IDLE
      press(0);
      chk("idle_inc_mode", 32'(mode), 32'd0);
      chk_digits("idle_inc_ignored", 1, 9);

      // Glitch and exact debounce latency in EDIT_MAX
      press(1);
      chk_digits("edit_max_19", 1, 9);
      key_n[0] = 1'b0;
      cyc(3);
      key_n[0] = 1'b1;
      cyc(12);
      chk_digits("glitch_3cyc", 1, 9);
      key_n[0] = 1'b0;
      cyc(4);
      key_n[0] = 1'b1;
      cyc(2);
      chk_digits("before_latency", 1, 9);
      cyc(1);
      chk_digits("after_latency_9_to_10", 2, 0);
      cyc(10);

      // Commit 20/12 (binary conversion of a tens-only value)
      press(1);
      chk_digits("min_load_2", 0, 2);
      repeat (10) press(0);
      chk_digits("min_12", 1, 2);
      commit("commit_20_12", 6'd20, 6'd12);

      // Max wraps at MAX_VAL, then clamp of min into new max
      press(1);
      repeat (11) press(0);
      chk_digits("max_31", 3, 1);
      press(0);
      chk_digits("max_wrap", 0, 0);
      repeat (5) press(0);
      chk_digits("max_5", 0, 5);
      press(1);
      chk("clamp_mode", 32'(mode), 32'd2);
      chk_digits("min_clamped", 0, 5);
      press(0);
      chk_digits("min_wrap_at_max", 0, 0);
      commit("commit_5_0", 6'd5, 6'd0);

      // Asynchronous reset in the middle of EDIT_MIN
      press(1);
      press(1);
      chk("pre_rst_mode", 32'(mode), 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_max", 32'(max_o), 32'd15);
      chk("mid_rst_min", 32'(min_o), 32'd0);
      chk("mid_rst_mode", 32'(mode), 32'd0);
      chk("mid_rst_upd", 32'(upd), 32'd0);
      chk_digits("mid_rst_digits", 1, 5);
      cyc(2);
      rst = 1'b0;
      seen_upd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (upd !== 1'b0) seen_upd = 1'b1;
      end
      chk("post_rst_no_upd", 32'(seen_upd), 32'd0);

      // Select and increment together in EDIT_MAX: select wins
      press(1);
      chk_digits("simul_start", 1, 5);
      key_n = 2'b00;
      cyc(8);
      key_n = 2'b11;
      cyc(10);
      chk("simul_mode", 32'(mode), 32'd2);
      chk_digits("simul_min_load", 0, 0);
      commit("commit_simul", 6'd15, 6'd0);

      // Long hold of increment in EDIT_MAX
      press(1);
      key_n[0] = 1'b0;
      cyc(456);
      key_n[0] = 1'b1;
      cyc(12);
`ifdef BOUND_SETTER_AUTOREPEAT_EN
      chk_digits("long_hold", 1, 9);
      press(1);
      commit("commit_hold", 6'd19, 6'd0);
`else
      chk_digits("long_hold", 1, 6);
      press(1);
      commit("commit_hold", 6'd16, 6'd0);
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
